abi_decoder: RTL

Quadrature (A/B/Index) encoder front-end for the BLDC motor path. Synchronises and optionally deglitches raw encoder inputs, decodes quadrature edges into single-cycle step triggers with direction, and tracks a wrapping rotor position with index-based re-zeroing. Sits directly upstream of the commutation pattern generator: `o_step_trigger` and `o_step_dir` feed that block's step trigger and polarity inputs.

---
 rtl/motor_pkg.sv | 21 ++
 rtl/abi_input_filter.sv | 67 ++++++
 rtl/abi_decoder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/motor_pkg.sv
// Shared motor-path types: quadrature decoder FSM states, the 2-bit {A,B} state type
// and the forward-successor rule for the quadrature sequence 00 -> 10 -> 11 -> 01 -> 00.
package motor_pkg;

  typedef enum logic {
    INIT,
    TRACK
  } abi_state_e;

  typedef logic [1:0] quad_t;

  function automatic quad_t quad_fwd_next(input quad_t q);
    case (q)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/abi_input_filter.sv
// Single-bit 2-FF synchroniser followed by an optional debounce filter.
// With ABI_FILTER_EN defined the output flips only after K_FILTER_LEN consecutive differing cycles.
module abi_input_filter
`ifdef ABI_FILTER_EN
  #(parameter int K_FILTER_LEN = 4)
`endif
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_filt
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = i_raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef ABI_FILTER_EN
  localparam int CW = (K_FILTER_LEN > 1) ? $clog2(K_FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(K_FILTER_LEN - 1);

  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only advances while the input disagrees; the K-th disagreeing cycle flips the output.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_filt = filt_q;
`else
  assign o_filt = sync2_q;
`endif

endmodule

// File: rtl/abi_decoder.sv
// Quadrature A/B/Index front-end: step triggers with direction, wrapping position, index re-zero.
// Optional input debounce is compiled in with ABI_FILTER_EN.
module abi_decoder
  import motor_pkg::*;
#(
  parameter int K_CPR        = 4096,
  parameter int K_FILTER_LEN = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_a,
  input  logic                     i_b,
  input  logic                     i_i,
  input  logic                     i_enable,
  input  logic                     i_dir_invert,
  input  logic                     i_index_clear_en,
  input  logic                     i_err_clear,
  output logic                     o_step_trigger,
  output logic                     o_step_dir,
  output logic [$clog2(K_CPR)-1:0] o_position,
  output logic                     o_index_pulse,
  output logic                     o_index_seen,
  output logic                     o_err_illegal
);

  localparam int PW = $clog2(K_CPR);
`ifdef ABI_FILTER_EN
  localparam int INIT_LEN = K_FILTER_LEN + 3;
`else
  localparam int INIT_LEN = 3;
`endif
  // Init counter is sized for the filtered build so both builds share one declaration.
  localparam int ICW = $clog2(K_FILTER_LEN + 4);
  localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_LEN - 1);
  localparam logic [PW-1:0]  POS_MAX   = PW'(K_CPR - 1);

  logic a_f, b_f, i_f;

`ifdef ABI_FILTER_EN
  abi_input_filter #(.K_FILTER_LEN(K_FILTER_LEN)) u_filt_a (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_raw(i_a), .o_filt(a_f));
  abi_input_filter #(.K_FILTER_LEN(K_FILTER_LEN)) u_filt_b (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_raw(i_b), .o_filt(b_f));
  abi_input_filter #(.K_FILTER_LEN(K_FILTER_LEN)) u_filt_i (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_raw(i_i), .o_filt(i_f));
`else
  abi_input_filter u_filt_a (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_raw(i_a), .o_filt(a_f));
  abi_input_filter u_filt_b (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_raw(i_b), .o_filt(b_f));
  abi_input_filter u_filt_i (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_raw(i_i), .o_filt(i_f));
`endif

  abi_state_e     state_q, state_d;
  logic [ICW-1:0] init_cnt_q, init_cnt_d;
  quad_t          ref_ab_q, ref_ab_d;
  logic           ref_i_q, ref_i_d;
  logic           step_trigger_q, step_trigger_d;
  logic           step_dir_q, step_dir_d;
  logic [PW-1:0]  position_q, position_d;
  logic           index_pulse_q, index_pulse_d;
  logic           index_seen_q, index_seen_d;
  logic           err_illegal_q, err_illegal_d;

  quad_t         cur_ab;
  logic          is_fwd, is_bwd;
  logic [PW-1:0] pos_inc, pos_dec;

  assign cur_ab  = {a_f, b_f};
  assign is_fwd  = (cur_ab == quad_fwd_next(ref_ab_q));
  assign is_bwd  = (ref_ab_q == quad_fwd_next(cur_ab));
  // Explicit wrap compares keep the modulo correct for non-power-of-2 K_CPR.
  assign pos_inc = (position_q == POS_MAX) ? '0 : position_q + 1'b1;
  assign pos_dec = (position_q == '0) ? POS_MAX : position_q - 1'b1;

  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    ref_ab_d       = ref_ab_q;
    ref_i_d        = ref_i_q;
    step_trigger_d = 1'b0;
    step_dir_d     = step_dir_q;
    position_d     = position_q;
    index_pulse_d  = 1'b0;
    index_seen_d   = index_seen_q;
    err_illegal_d  = err_illegal_q;

    if (i_err_clear) begin
      err_illegal_d = 1'b0;
    end

    case (state_q)
      INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          ref_ab_d = cur_ab;
          ref_i_d  = i_f;
          state_d  = TRACK;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      TRACK: begin
        ref_ab_d = cur_ab;
        ref_i_d  = i_f;
        if (is_fwd || is_bwd) begin
          if (i_enable) begin
            step_trigger_d = 1'b1;
            step_dir_d     = is_bwd ^ i_dir_invert;
            position_d     = (is_bwd ^ i_dir_invert) ? pos_dec : pos_inc;
          end
        end else if (cur_ab != ref_ab_q) begin
          err_illegal_d = 1'b1;
        end
        // Index re-zero overrides any simultaneous +/-1 but the step trigger still fires.
        if (i_f && !ref_i_q) begin
          index_pulse_d = 1'b1;
          index_seen_d  = 1'b1;
          if (i_index_clear_en && i_enable) begin
            position_d = '0;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= INIT;
      init_cnt_q     <= '0;
      ref_ab_q       <= 2'b00;
      ref_i_q        <= 1'b0;
      step_trigger_q <= 1'b0;
      step_dir_q     <= 1'b0;
      position_q     <= '0;
      index_pulse_q  <= 1'b0;
      index_seen_q   <= 1'b0;
      err_illegal_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      init_cnt_q     <= init_cnt_d;
      ref_ab_q       <= ref_ab_d;
      ref_i_q        <= ref_i_d;
      step_trigger_q <= step_trigger_d;
      step_dir_q     <= step_dir_d;
      position_q     <= position_d;
      index_pulse_q  <= index_pulse_d;
      index_seen_q   <= index_seen_d;
      err_illegal_q  <= err_illegal_d;
    end
  end

  assign o_step_trigger = step_trigger_q;
  assign o_step_dir     = step_dir_q;
  assign o_position     = position_q;
  assign o_index_pulse  = index_pulse_q;
  assign o_index_seen   = index_seen_q;
  assign o_err_illegal  = err_illegal_q;

endmodule
